// File: rtl/connect4_move_dropper.sv
// Connect Four move executor: checks a one-hot column move, drops the piece and commits it
// to the red/black boards. Define DROP_ANIM_EN to enable the row-by-row fall animation.
module connect4_move_dropper #(
    parameter int DROP_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        move_valid,
    input  logic [7:0]  move_col,
    input  logic        player,
    output logic        move_ready,
    output logic [41:0] r_board,
    output logic [41:0] b_board,
    output logic        c_a,
    output logic        c_b,
    output logic        c_c,
    output logic        c_d,
    output logic        c_e,
    output logic        c_f,
    output logic        c_g,
    output logic        drop_active,
    output logic [2:0]  drop_row,
    output logic [2:0]  drop_col,
    output logic        done,
    output logic        illegal,
    output logic        board_full
);
    // state | meaning
    // IDLE  | waiting for a move, move_ready high
    // CHECK | legality test on the captured move
    // FALL  | piece drops one row every DROP_TICKS cycles (animated build only)
    // DONE  | one-cycle result: done + c_x on commit, illegal on reject

    if (DROP_TICKS < 1 || DROP_TICKS > 255) begin : g_bad_ticks
        $error("DROP_TICKS must be in 1..255");
    end

`ifdef DROP_ANIM_EN
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FALL, S_DONE} state_t;
    localparam logic [7:0] TICK_LOAD = 8'(DROP_TICKS - 1);
    logic [7:0] tick;
    logic [2:0] target;
    logic       start;
    logic       step;
`else
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;
`endif

    state_t     state, next_state;
    logic [7:0] mcol;
    logic       player_q;
    logic       rej;
    logic [2:0] heights [7];

    logic [2:0]  col_idx;
    logic [2:0]  ones;
    logic [2:0]  sel_height;
    logic        legal;
    logic        load;
    logic        reject;
    logic        commit;
    logic [2:0]  commit_row;
    logic [2:0]  commit_col;
    logic [5:0]  commit_idx;
    logic [41:0] commit_mask;

    always_comb begin
        col_idx    = 3'd0;
        ones       = 3'd0;
        sel_height = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (mcol[i+1]) begin
                col_idx    = 3'(i);
                ones       = ones + 3'd1;
                sel_height = heights[i];
            end
        end
        legal = (ones == 3'd1) && !mcol[0] && (sel_height != 3'd6);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) state <= S_IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        reject     = 1'b0;
        commit     = 1'b0;
`ifdef DROP_ANIM_EN
        start      = 1'b0;
        step       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (move_valid) begin
                    next_state = S_CHECK;
                    load       = 1'b1;
                end
            end
            S_CHECK: begin
                if (!legal) begin
                    next_state = S_DONE;
                    reject     = 1'b1;
                end else begin
`ifdef DROP_ANIM_EN
                    next_state = S_FALL;
                    start      = 1'b1;
`else
                    next_state = S_DONE;
                    commit     = 1'b1;
`endif
                end
            end
`ifdef DROP_ANIM_EN
            S_FALL: begin
                if (tick == 8'd0) begin
                    if (drop_row == target) begin
                        commit     = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

`ifdef DROP_ANIM_EN
    assign commit_row = target;
    assign commit_col = drop_col;
`else
    assign commit_row = sel_height;
    assign commit_col = col_idx;
`endif
    assign commit_idx  = 6'(commit_row) * 6'd7 + 6'(commit_col);
    assign commit_mask = 42'd1 << commit_idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_board  <= '0;
            b_board  <= '0;
            mcol     <= '0;
            player_q <= 1'b0;
            rej      <= 1'b0;
            drop_row <= 3'd0;
            drop_col <= 3'd0;
            for (int i = 0; i < 7; i++) heights[i] <= 3'd0;
`ifdef DROP_ANIM_EN
            tick     <= 8'd0;
            target   <= 3'd0;
`endif
        end else begin
            if (load) begin
                mcol     <= move_col;
                player_q <= player;
                rej      <= 1'b0;
            end
            if (reject) rej <= 1'b1;
`ifdef DROP_ANIM_EN
            // tick is a down-counter: a row is held for DROP_TICKS cycles ending at zero
            if (start) begin
                target   <= sel_height;
                drop_row <= 3'd5;
                drop_col <= col_idx;
                tick     <= TICK_LOAD;
            end else if (step) begin
                drop_row <= drop_row - 3'd1;
                tick     <= TICK_LOAD;
            end else if (state == S_FALL && tick != 8'd0) begin
                tick <= tick - 8'd1;
            end
`else
            if (commit) begin
                drop_row <= sel_height;
                drop_col <= col_idx;
            end
`endif
            if (commit) begin
                if (player_q) b_board <= b_board | commit_mask;
                else          r_board <= r_board | commit_mask;
                for (int i = 0; i < 7; i++) begin
                    if (commit_col == 3'(i)) heights[i] <= heights[i] + 3'd1;
                end
            end
        end
    end

    assign move_ready = (state == S_IDLE);
    assign done       = (state == S_DONE) && !rej;
    assign illegal    = (state == S_DONE) && rej;
`ifdef DROP_ANIM_EN
    assign drop_active = (state == S_FALL);
`else
    assign drop_active = 1'b0;
`endif

    logic [6:0] col_pulse;
    assign col_pulse = done ? (7'd1 << drop_col) : 7'd0;
    assign {c_g, c_f, c_e, c_d, c_c, c_b, c_a} = col_pulse;

    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (heights[i] != 3'd6) board_full = 1'b0;
        end
    end
endmodule

// File: tb/tb_connect4_move_dropper.sv
// Randomized bench for connect4_move_dropper against a board/height model; builds with or
// without DROP_ANIM_EN.
module tb_connect4_move_dropper;
    localparam int T = 4;
`ifdef DROP_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        move_valid = 1'b0;
    logic [7:0]  move_col = 8'd0;
    logic        player = 1'b0;
    logic        move_ready;
    logic [41:0] r_board, b_board;
    logic        c_a, c_b, c_c, c_d, c_e, c_f, c_g;
    logic        drop_active;
    logic [2:0]  drop_row, drop_col;
    logic        done, illegal, board_full;
    logic [6:0]  cvec;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [41:0] m_r, m_b;
    int          m_h [7];
    int          bad;
    logic [7:0]  rcol;

    connect4_move_dropper #(.DROP_TICKS(T)) dut (
        .clk(clk), .reset(reset), .clear(clear), .move_valid(move_valid),
        .move_col(move_col), .player(player), .move_ready(move_ready),
        .r_board(r_board), .b_board(b_board),
        .c_a(c_a), .c_b(c_b), .c_c(c_c), .c_d(c_d), .c_e(c_e), .c_f(c_f), .c_g(c_g),
        .drop_active(drop_active), .drop_row(drop_row), .drop_col(drop_col),
        .done(done), .illegal(illegal), .board_full(board_full)
    );

    assign cvec = {c_g, c_f, c_e, c_d, c_c, c_b, c_a};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_r = '0;
        m_b = '0;
        for (int i = 0; i < 7; i++) m_h[i] = 0;
    endtask

    function automatic bit model_full();
        for (int i = 0; i < 7; i++) if (m_h[i] != 6) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_move(input logic [7:0] col, input logic pl);
        int idx, tgt, lat, n, waited, errs;
        bit ok;
        logic [41:0] er, eb;
        logic [6:0] ec;
        idx = 0;
        for (int i = 0; i < 7; i++) if (col[i+1]) idx = i;
        ok  = ($countones(col[7:1]) == 1) && !col[0] && (m_h[idx] < 6);
        tgt = ok ? m_h[idx] : 0;
        lat = (ok && ANIM) ? 2 + (6 - tgt) * T : 2;
        er = m_r;
        eb = m_b;
        ec = '0;
        if (ok) begin
            if (pl) eb[tgt*7 + idx] = 1'b1;
            else    er[tgt*7 + idx] = 1'b1;
            ec[idx] = 1'b1;
        end
        waited = 0;
        while (!move_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_wait", move_ready, 1);
        // request is held through CHECK/FALL; it must be ignored there
        move_valid = 1'b1;
        move_col   = col;
        player     = pl;
        @(posedge clk); #1;
        n = 1;
        errs = 0;
        while (!done && !illegal && n < lat + 10) begin
            if (drop_active !== (ANIM && ok && n >= 2)) errs++;
            if (ANIM && ok && n >= 2 && drop_row !== 3'(5 - (n - 2) / T)) errs++;
            if (cvec !== 7'd0) errs++;
            @(posedge clk); #1;
            n++;
        end
        move_valid = 1'b0;
        check("latency", n, lat);
        check("done", done, ok);
        check("illegal", illegal, !ok);
        check("c_pulse", cvec, ec);
        check("r_board", r_board, er);
        check("b_board", b_board, eb);
        check("fall_track", errs, 0);
        if (ok) begin
            check("drop_row_end", drop_row, tgt);
            check("drop_col_end", drop_col, idx);
        end
        m_r = er;
        m_b = eb;
        if (ok) m_h[idx]++;
        @(posedge clk); #1;
        check("ready_after", move_ready, 1);
        check("done_once", done, 0);
        check("board_full", board_full, model_full());
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        check("clr_r", r_board, 0);
        check("clr_b", b_board, 0);
        check("clr_full", board_full, 0);
        check("clr_ready", move_ready, 1);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", move_ready, 1);
        check("rst_r", r_board, 0);
        check("rst_b", b_board, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_active", drop_active, 0);
        check("rst_row", drop_row, 0);
        check("rst_col", drop_col, 0);
        check("rst_cx", cvec, 0);
        check("rst_full", board_full, 0);

        do_move(8'b0001_0000, 1'b0);
        check("d_r", r_board, 42'h8);
        check("d_b", b_board, 42'h0);
        do_clear();

        for (int k = 0; k < 6; k++) do_move(8'b0000_0010, 1'(k % 2));
        check("colA_r", r_board, (42'd1 << 0) | (42'd1 << 14) | (42'd1 << 28));
        check("colA_b", b_board, (42'd1 << 7) | (42'd1 << 21) | (42'd1 << 35));
        do_move(8'b0000_0010, 1'b0);

        do_move(8'b0000_0000, 1'b1);
        do_move(8'b0000_0110, 1'b0);
        do_move(8'b0000_0001, 1'b1);

        // abort a column-G move mid-flight (during FALL when animated, CHECK otherwise)
        move_valid = 1'b1;
        move_col   = 8'b1000_0000;
        player     = 1'b0;
        @(posedge clk); #1;
        move_valid = 1'b0;
        bad = 0;
        repeat ((ANIM ? 5 : 1) - 1) begin
            if (done || cvec != 7'd0) bad++;
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        check("abort_no_done", bad + int'(done) + int'(cvec != 7'd0), 0);
        check("abort_r", r_board, 0);
        check("abort_b", b_board, 0);
        check("abort_ready", move_ready, 1);
        check("abort_active", drop_active, 0);
        do_move(8'b1000_0000, 1'b1);

        for (int m = 0; m < 600 && !model_full(); m++) begin
            if ($urandom_range(0, 9) == 0) rcol = 8'($urandom);
            else                           rcol = 8'd1 << (1 + $urandom_range(0, 6));
            do_move(rcol, 1'($urandom_range(0, 1)));
        end
        check("full_end", board_full, 1);
        check("full_cells", $countones(r_board | b_board), 42);
        check("full_disjoint", r_board & b_board, 0);
        do_move(8'b0000_1000, 1'b0);
        do_clear();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/connect4_move_dropper.md
# connect4_move_dropper

Executes one column move for Connect Four: accepts a one-hot column choice from the AI move chooser or the human column selector, finds the lowest free cell, animates the piece falling row by row, then commits it to the red or black 42-bit board. It owns the `r_board`/`b_board` registers and the per-column increment pulses (`c_a`..`c_g`) that the AI move chooser and the VGA/board display consume.

## Interface
- `DROP_TICKS`, default 4: cycles per one-row fall step, range 1..255.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `clear  in  1`: synchronous new-game clear; same effect as `reset` on all state.
- `move_valid  in  1`: move request.
- `move_col  in  8`: one-hot column. Bit 1 is column 0 (A), …, bit 7 is column 6 (G). Bit 0 is unused.
- `player  in  1`: 0 = red, 1 = black. Sampled with the move.
- `move_ready  out  1`: high only in IDLE.
- `r_board  out  42`, `b_board  out  42`: occupancy. Index = row*7 + col; row 0 is the bottom row.
- `c_a`..`c_g  out  1` each: one-cycle pulse on commit to column A..G.
- `drop_active  out  1`, `drop_row  out  3`, `drop_col  out  3`: falling-piece position for the display.
- `done  out  1`: one-cycle pulse on commit.
- `illegal  out  1`: one-cycle pulse on a rejected move.
- `board_full  out  1`: all seven columns hold 6 pieces.

## Operation
- Internal state: seven 3-bit column heights (0..6), captured column and player, target row, tick counter.
- States: IDLE, CHECK, FALL, DONE.
- IDLE: `move_ready`=1. The move is accepted on the edge where `move_valid && move_ready`. `move_col` and `player` are registered and the state goes to CHECK.
- CHECK (1 cycle): the move is illegal if `move_col[7:1]` does not have exactly one bit set, or `move_col[0]`=1, or the selected column height is 6.
  - Illegal: `illegal`=1 for one cycle, then IDLE. Boards and heights are unchanged.
  - Legal: target row = height, `drop_row`=5, `drop_col`=column, tick counter=0, then FALL.
- FALL: `drop_active`=1. The tick counter counts 0..`DROP_TICKS`-1. When it reaches its maximum:
  - if `drop_row`==target: set board bit (target*7 + col) in `r_board` (player 0) or `b_board` (player 1), increment that column's height, go to DONE;
  - otherwise decrement `drop_row` and restart the counter.
- DONE (1 cycle): `done`=1 and the matching `c_x`=1, with the new board already visible; `move_ready`=0. Then IDLE.
- A board bit is never written twice; heights never exceed 6.
- `board_full` is derived from registers: it is 1 when every height is 6.
- `move_valid` outside IDLE is ignored; the source holds the request.
- `clear` or `reset` asserted mid-move aborts the move: no `done`, no `c_x`, no board write, state returns to IDLE.
- Priority is `reset` > `clear` > FSM.

## Timing
- Reset/clear values:
  - `r_board`=`b_board`=0, heights 0, state IDLE;
  - `move_ready`=1 from the first cycle after reset;
  - `drop_active`=0, `drop_row`=0, `drop_col`=0, `done`=`illegal`=`c_a`..`c_g`=0, `board_full`=0.
- All outputs are registered or decoded from registers; there is no input-to-output combinational path.
- Accept edge = E. CHECK occupies the cycle after E.
- FALL lasts (6 − target) × `DROP_TICKS` cycles. The board is written on FALL's last edge.
- `done` is high on cycle E + 2 + (6 − target) × `DROP_TICKS`. `move_ready` returns on the next cycle.
- Illegal move: `illegal` is high on cycle E+2; `move_ready` returns on E+3.
- Example: `DROP_TICKS`=4, empty column → `done` on E+26, next accept possible on edge E+27.

## Configuration
- `DROP_ANIM_EN` defined: FALL animation as above.
- Not defined:
  - FALL state and tick counter are compiled out; CHECK goes straight to DONE and writes the board on its edge;
  - `done` is on E+2, `drop_active` stays 0, and `drop_row` shows the target row;
  - `DROP_TICKS` is ignored.
- Legality checks and board encoding are identical in both builds.

## Test plan
- Reset, then red move `move_col`=8'b00010000 (column D) with `DROP_TICKS`=4 → `drop_row` steps 5,4,3,2,1,0 every 4 cycles; `done` and `c_d` on E+26; `r_board`=42'h8 (bit 3); `b_board`=0.
- Six alternating moves into column A, then a seventh → heights 6; bits 0,7,14,21,28,35 set alternately in red/black; seventh move gives `illegal` on E+2 with boards unchanged.
- `move_col`=8'b00000000, then 8'b00000110, then 8'b00000001 → each gives a single `illegal` pulse, no `c_x` pulse, `move_ready` back after 3 cycles.
- Fill all 42 cells → `board_full`=1 on the cycle after the final `done`; assert `clear` → boards 0, `board_full`=0 next cycle.
- Assert `clear` during FALL of a column-G move → no `done`, no `c_g`, boards 0; new move accepted on the next cycle.
- Build without `DROP_ANIM_EN`, black move to column B on an empty board → `done` and `c_b` on E+2, `b_board`=42'h2, `drop_active` never high.
